// File: rtl/bcd_counter_pkg.sv
// Shared definitions for the BCD up/down counter: state encoding, digit limit
// and the all-nines constant builder.
package bcd_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STOP  = 2'b01,
        ST_COUNT = 2'b10
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // BCD word with the low ndig digits set to 9 (up to 8 digits).
    function automatic logic [31:0] bcd_all_nines(input int ndig);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < ndig) r[4*i +: 4] = BCD_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit of the count ripple chain: steps the digit by one when cin is
// set and reports carry (up from 9) or borrow (down from 0) on cout.
module bcd_digit_step
    import bcd_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       cin,
    input  logic       up,
    output logic [3:0] out,
    output logic       cout
);

    always_comb begin
        out  = digit;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    out  = 4'd0;
                    cout = 1'b1;
                end else begin
                    out = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    out  = BCD_MAX;
                    cout = 1'b1;
                end else begin
                    out = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with IDLE/STOP/COUNT control and per-digit editing.
// Define BCD_WRAP_EN to wrap at 9..9 / 0 in COUNT instead of saturating.
module bcd_updown_counter
    import bcd_counter_pkg::*;
#(
    parameter int                NDIG     = 3,
    parameter logic [4*NDIG-1:0] INIT_VAL = 12'h050,
    parameter int                TICK_DIV = 8388608
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_p,
    input  logic              dir_p,
    input  logic              inc_p,
    input  logic              dec_p,
    input  logic              sel_p,
    output logic [1:0]        state,
    output logic [4*NDIG-1:0] value,
    output logic              dir,
    output logic [NDIG-1:0]   sel_oh,
    output logic              at_max,
    output logic              at_min,
    output logic              step_p
);

    localparam int VW = 4 * NDIG;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [31:0]   NINES32 = bcd_all_nines(NDIG);
    localparam logic [VW-1:0] NINES   = NINES32[VW-1:0];

`ifdef BCD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_t        st;
    logic [VW-1:0] val;
    logic          dir_q;
    logic [SW-1:0] sel;
    logic [PW-1:0] presc;
    logic          step_q;

    logic          tick;
    logic          apply;
    logic [NDIG:0] carry;
    logic [VW-1:0] stepped;
    logic [3:0]    cur_d;

    assign tick     = (st == ST_COUNT) && (presc == PW'(TICK_DIV - 1));
    assign carry[0] = tick;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_dig
            bcd_digit_step u_step (
                .digit (val[4*g +: 4]),
                .cin   (carry[g]),
                .up    (!dir_q),
                .out   (stepped[4*g +: 4]),
                .cout  (carry[g+1])
            );
        end
    endgenerate

    // A carry out of the top digit means the step crosses the 9..9 / 0 boundary.
    assign apply = tick && (WRAP || !carry[NDIG]);

    always_comb begin
        cur_d = val[4*int'(sel) +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= ST_IDLE;
            val    <= INIT_VAL;
            dir_q  <= 1'b0;
            sel    <= '0;
            presc  <= '0;
            step_q <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (st)
                ST_IDLE: begin
                    presc <= '0;
                    val   <= INIT_VAL;
                    sel   <= '0;
                    if (start_p) st <= ST_STOP;
                end
                ST_STOP: begin
                    presc <= '0;
                    if (start_p) st <= ST_COUNT;
                    if (inc_p) begin
                        if (cur_d != BCD_MAX) val[4*int'(sel) +: 4] <= cur_d + 4'd1;
                    end else if (dec_p) begin
                        if (cur_d != 4'd0) val[4*int'(sel) +: 4] <= cur_d - 4'd1;
                    end
                    if (sel_p) sel <= (sel == SW'(NDIG - 1)) ? '0 : sel + SW'(1);
                end
                ST_COUNT: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (apply) begin
                        val    <= stepped;
                        step_q <= 1'b1;
                    end
                    if (dir_p)   dir_q <= ~dir_q;
                    if (start_p) st    <= ST_STOP;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NDIG; i++) sel_oh[i] = (sel == SW'(i));
    end

    assign state  = st;
    assign value  = val;
    assign dir    = dir_q;
    assign step_p = step_q;
    assign at_max = (val == NINES);
    assign at_min = (val == '0);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a decimal-integer reference model
// pushes expected outputs per cycle, a monitor pops and compares after each edge.
module tb_bcd_updown_counter;

    localparam int NDIG = 3;
    localparam int TD   = 4;
    localparam logic [11:0] INIT = 12'h050;
`ifdef BCD_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_p, dir_p, inc_p, dec_p, sel_p;
    logic [1:0]  state;
    logic [11:0] value;
    logic        dir;
    logic [2:0]  sel_oh;
    logic        at_max, at_min, step_p;

    always #5 clk = ~clk;

    bcd_updown_counter #(.NDIG(NDIG), .INIT_VAL(INIT), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst),
        .start_p(start_p), .dir_p(dir_p), .inc_p(inc_p), .dec_p(dec_p), .sel_p(sel_p),
        .state(state), .value(value), .dir(dir), .sel_oh(sel_oh),
        .at_max(at_max), .at_min(at_min), .step_p(step_p)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [11:0] v;
        logic        d;
        logic [2:0]  oh;
        logic        mx;
        logic        mn;
        logic        sp;
    } exp_t;

    exp_t  q[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    // Reference model: value kept as a plain decimal integer 0..999.
    int m_st, m_val, m_dir, m_sel, m_pre;
    bit m_step;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.st = 2'(m_st);
        e.v  = to_bcd(m_val);
        e.d  = m_dir[0];
        e.oh = 3'(1 << m_sel);
        e.mx = (m_val == 999);
        e.mn = (m_val == 0);
        e.sp = m_step;
        return e;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_val = 50; m_dir = 0; m_sel = 0; m_pre = 0; m_step = 0;
    endfunction

    function automatic void model_step(input bit s, d, i, de, se);
        int p, dg;
        m_step = 0;
        case (m_st)
            0: begin
                m_val = 50; m_sel = 0;
                if (s) m_st = 1;
            end
            1: begin
                p  = 10 ** m_sel;
                dg = (m_val / p) % 10;
                if (i) begin
                    if (dg < 9) m_val += p;
                end else if (de) begin
                    if (dg > 0) m_val -= p;
                end
                if (se) m_sel = (m_sel + 1) % NDIG;
                if (s) begin m_st = 2; m_pre = 0; end
            end
            default: begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    if (m_dir == 0) begin
                        if (m_val < 999) begin m_val++; m_step = 1; end
                        else if (WRAP) begin m_val = 0; m_step = 1; end
                    end else begin
                        if (m_val > 0) begin m_val--; m_step = 1; end
                        else if (WRAP) begin m_val = 999; m_step = 1; end
                    end
                end else begin
                    m_pre++;
                end
                if (d) m_dir ^= 1;
                if (s) m_st = 1;
            end
        endcase
    endfunction

    task automatic check(input string nm, input exp_t e);
        exp_t a;
        a = {state, value, dir, sel_oh, at_max, at_min, step_p};
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t: got st=%0d val=%h dir=%0d oh=%b max=%0d min=%0d step=%0d; want st=%0d val=%h dir=%0d oh=%b max=%0d min=%0d step=%0d",
                     nm, $time, a.st, a.v, a.d, a.oh, a.mx, a.mn, a.sp,
                     e.st, e.v, e.d, e.oh, e.mx, e.mn, e.sp);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every clock edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check(phase, q.pop_front());
        end
    end

    task automatic cyc(input bit s, d, i, de, se);
        @(negedge clk);
        start_p = s; dir_p = d; inc_p = i; dec_p = de; sel_p = se;
        model_step(s, d, i, de, se);
        q.push_back(snap());
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        start_p = 0; dir_p = 0; inc_p = 0; dec_p = 0; sel_p = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check({phase, "_async_rst"}, snap());
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_sel(input int k);
        while (m_sel != k) cyc(0, 0, 0, 0, 1);
    endtask

    // STOP-mode editing driven from the model's view of the current value.
    task automatic set_val(input int v);
        int p, dg, cur;
        for (int k = 0; k < NDIG; k++) begin
            goto_sel(k);
            p  = 10 ** k;
            dg = (v / p) % 10;
            cur = (m_val / p) % 10;
            while (cur != dg) begin
                cyc(0, 0, cur < dg, cur > dg, 0);
                cur = (m_val / p) % 10;
            end
        end
        goto_sel(0);
    endtask

    initial begin
        rst = 1'b1;
        start_p = 0; dir_p = 0; inc_p = 0; dec_p = 0; sel_p = 0;
        model_reset();
        #2;
        check("reset", snap());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        phase = "start_first_step";
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(4);

        phase = "stop_edit";
        cyc(1, 0, 0, 0, 0);
        set_val(59);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);

        phase = "carry_then_down";
        set_val(99);
        cyc(1, 0, 0, 0, 0);
        idle(4);
        cyc(0, 1, 0, 0, 0);
        idle(3);

        phase = "up_at_max";
        cyc(1, 0, 0, 0, 0);
        set_val(999);
        cyc(1, 0, 0, 0, 0);
        if (m_dir != 0) cyc(0, 1, 0, 0, 0);
        idle(10);

        phase = "down_at_min";
        cyc(1, 0, 0, 0, 0);
        set_val(0);
        cyc(1, 0, 0, 0, 0);
        if (m_dir != 1) cyc(0, 1, 0, 0, 0);
        idle(10);

        phase = "inc_dec_same";
        cyc(1, 0, 0, 0, 0);
        set_val(5);
        cyc(0, 0, 1, 1, 0);
        phase = "start_with_tick";
        cyc(1, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0);
        idle(2);

        phase = "rst_mid_count";
        set_val(734);
        cyc(1, 0, 0, 0, 0);
        if (m_dir != 1) cyc(0, 1, 0, 0, 0);
        idle(1);
        do_reset();
        idle(2);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
            end
        end

        phase = "drain";
        @(negedge clk);
        start_p = 0; dir_p = 0; inc_p = 0; dec_p = 0; sel_p = 0;
        for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
